decode_stage: RTL

- Instruction decode stage directly downstream of the fetch block.
- Pops 32-bit instructions and their PCs from the fetch FIFO, decodes the RV32I base subset and sign-extends immediates.
- Detects load-use hazards against the instruction it currently holds and inserts bubbles.
- Presents one registered decode packet per cycle to execute, under stall and branch-flush control.

---
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-decode-to-execute bundle for decode_stage: FIFO head/pop, stall/flush and the decode packet.
// The slave modport is the decode stage; the master modport is its fetch/execute surroundings.
interface decode_stage_if #(parameter int XLEN = 32);
  logic [31:0]     inst_in;
  logic [XLEN-1:0] pc_in;
  logic            inst_valid;
  logic            inst_rd;
  logic            stall_in;
  logic            flush;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            dec_is_load;
  logic            dec_is_store;
  logic            dec_is_branch;
  logic            dec_is_jal;
  logic            dec_is_jalr;
  logic            dec_is_lui;
  logic            dec_is_auipc;
  logic            dec_use_imm;
  logic            dec_we;
  logic            dec_illegal;

  modport master (
    output inst_in, pc_in, inst_valid, stall_in, flush,
    input  inst_rd, dec_valid, dec_pc, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_alu_op,
           dec_is_load, dec_is_store, dec_is_branch, dec_is_jal, dec_is_jalr,
           dec_is_lui, dec_is_auipc, dec_use_imm, dec_we, dec_illegal
  );

  modport slave (
    input  inst_in, pc_in, inst_valid, stall_in, flush,
    output inst_rd, dec_valid, dec_pc, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_alu_op,
           dec_is_load, dec_is_store, dec_is_branch, dec_is_jal, dec_is_jalr,
           dec_is_lui, dec_is_auipc, dec_use_imm, dec_we, dec_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: pops the fetch FIFO, decodes into a registered packet, inserts load-use bubbles.
// Optional DECODE_ILLEGAL_TRAP_EN flags unlisted opcodes / bad branch funct3 as dec_illegal.
module decode_stage #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_lui;
    logic            is_auipc;
    logic            use_imm;
    logic            we;
    logic            illegal;
  } pkt_t;

  function automatic logic signed [31:0] imm_i(input logic [31:0] i);
    imm_i = {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] i);
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] i);
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] i);
    imm_u = {i[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] i);
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  pkt_t       dec_p0;
  logic       use_rs1_p0;
  logic       use_rs2_p0;
  logic       hazard;
  pkt_t       pkt_p1;
  logic       vld_p1;
  logic [2:0] funct3;

  assign funct3 = bus.inst_in[14:12];

  // ---- p0: combinational decode of the FIFO head ----
  always_comb begin
    dec_p0        = '0;
    use_rs1_p0    = 1'b0;
    use_rs2_p0    = 1'b0;
    dec_p0.pc     = bus.pc_in;
    dec_p0.rs1    = bus.inst_in[19:15];
    dec_p0.rs2    = bus.inst_in[24:20];
    dec_p0.rd     = bus.inst_in[11:7];
    dec_p0.alu_op = {bus.inst_in[30], funct3};
    case (bus.inst_in[6:0])
      OP_R: begin
        dec_p0.we  = 1'b1;
        use_rs1_p0 = 1'b1;
        use_rs2_p0 = 1'b1;
      end
      OP_IMM: begin
        dec_p0.imm     = imm_i(bus.inst_in);
        dec_p0.use_imm = 1'b1;
        dec_p0.we      = 1'b1;
        use_rs1_p0     = 1'b1;
        // Only SRAI carries a meaningful funct7[5]; elsewhere those bits are immediate.
        if (funct3 != 3'b101) dec_p0.alu_op[3] = 1'b0;
      end
      OP_LOAD: begin
        dec_p0.imm     = imm_i(bus.inst_in);
        dec_p0.is_load = 1'b1;
        dec_p0.use_imm = 1'b1;
        dec_p0.we      = 1'b1;
        use_rs1_p0     = 1'b1;
      end
      OP_STORE: begin
        dec_p0.imm      = imm_s(bus.inst_in);
        dec_p0.is_store = 1'b1;
        dec_p0.use_imm  = 1'b1;
        use_rs1_p0      = 1'b1;
        use_rs2_p0      = 1'b1;
      end
      OP_BRANCH: begin
        dec_p0.imm       = imm_b(bus.inst_in);
        dec_p0.is_branch = 1'b1;
        use_rs1_p0       = 1'b1;
        use_rs2_p0       = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_p0.illegal = 1'b1;
`endif
      end
      OP_JAL: begin
        dec_p0.imm     = imm_j(bus.inst_in);
        dec_p0.is_jal  = 1'b1;
        dec_p0.use_imm = 1'b1;
        dec_p0.we      = 1'b1;
      end
      OP_JALR: begin
        dec_p0.imm     = imm_i(bus.inst_in);
        dec_p0.is_jalr = 1'b1;
        dec_p0.use_imm = 1'b1;
        dec_p0.we      = 1'b1;
        use_rs1_p0     = 1'b1;
      end
      OP_LUI: begin
        dec_p0.imm     = imm_u(bus.inst_in);
        dec_p0.is_lui  = 1'b1;
        dec_p0.use_imm = 1'b1;
        dec_p0.we      = 1'b1;
      end
      OP_AUIPC: begin
        dec_p0.imm       = imm_u(bus.inst_in);
        dec_p0.is_auipc  = 1'b1;
        dec_p0.use_imm   = 1'b1;
        dec_p0.we        = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_p0.illegal = 1'b1;
`endif
      end
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (dec_p0.illegal) begin
      {dec_p0.is_load, dec_p0.is_store, dec_p0.is_branch, dec_p0.is_jal} = '0;
      {dec_p0.is_jalr, dec_p0.is_lui, dec_p0.is_auipc, dec_p0.use_imm}   = '0;
      dec_p0.we = 1'b0;
    end
`endif
    if (dec_p0.rd == 5'd0) dec_p0.we = 1'b0;
  end

  // Load-use check of the FIFO head against the load currently held in p1.
  always_comb begin
    hazard = vld_p1 && pkt_p1.is_load && (pkt_p1.rd != 5'd0) && bus.inst_valid &&
             ((use_rs1_p0 && (dec_p0.rs1 == pkt_p1.rd)) ||
              (use_rs2_p0 && (dec_p0.rs2 == pkt_p1.rd)));
    bus.inst_rd = !rst && !bus.flush && !bus.stall_in && !hazard && bus.inst_valid;
  end

  // ---- p1: registered packet to execute ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pkt_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (bus.stall_in) begin
      vld_p1 <= vld_p1;
    end else if (hazard) begin
      vld_p1 <= 1'b0;
    end else if (bus.inst_valid) begin
      vld_p1 <= 1'b1;
      pkt_p1 <= dec_p0;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.dec_valid     = vld_p1;
  assign bus.dec_pc        = pkt_p1.pc;
  assign bus.dec_rs1       = pkt_p1.rs1;
  assign bus.dec_rs2       = pkt_p1.rs2;
  assign bus.dec_rd        = pkt_p1.rd;
  assign bus.dec_imm       = pkt_p1.imm;
  assign bus.dec_alu_op    = pkt_p1.alu_op;
  assign bus.dec_is_load   = pkt_p1.is_load;
  assign bus.dec_is_store  = pkt_p1.is_store;
  assign bus.dec_is_branch = pkt_p1.is_branch;
  assign bus.dec_is_jal    = pkt_p1.is_jal;
  assign bus.dec_is_jalr   = pkt_p1.is_jalr;
  assign bus.dec_is_lui    = pkt_p1.is_lui;
  assign bus.dec_is_auipc  = pkt_p1.is_auipc;
  assign bus.dec_use_imm   = pkt_p1.use_imm;
  assign bus.dec_we        = pkt_p1.we;
  assign bus.dec_illegal   = pkt_p1.illegal;

endmodule
